// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the CPU has fixed priority, and a starvation counter forces an auxiliary grant.
// Read data from the 1-cycle BRAM is steered back to the port that issued the read.
//
// state  | meaning
// NORMAL | CPU wins whenever active; aux served only when the CPU is idle
// FORCE  | CPU stalled for one cycle, aux port owns the memory
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [31:0] cpu_addr_i,
    input  logic        cpu_read_enable_i,
    input  logic [31:0] cpu_write_data_i,
    input  logic [3:0]  cpu_write_mask_i,
    output logic        cpu_stall_o,
    output logic [31:0] cpu_read_data_o,
    input  logic        aux_req_i,
    input  logic [31:0] aux_addr_i,
    input  logic        aux_we_i,
    input  logic [31:0] aux_write_data_i,
    input  logic [3:0]  aux_write_mask_i,
    output logic        aux_gnt_o,
    output logic        aux_rvalid_o,
    output logic [31:0] aux_read_data_o,
    output logic [31:0] dmem_addr_o,
    output logic        dmem_read_enable_o,
    output logic [31:0] dmem_write_data_o,
    output logic [3:0]  dmem_write_mask_o,
    input  logic [31:0] dmem_read_data_i
);

    typedef enum logic {NORMAL, FORCE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_AUX} owner_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t      state_q;
    owner_t      owner_q;
    owner_t      owner_d;
    logic [7:0]  starve_cnt_q;
    logic [7:0]  starve_cnt_inc;
    logic        cpu_active;
    logic        sel_cpu;
    logic        sel_aux;
    logic [31:0] addr_sel;

    assign cpu_active     = cpu_read_enable_i | (|cpu_write_mask_i);
    assign starve_cnt_inc = starve_cnt_q + 8'd1;

    // Selection is gated by reset so nothing reaches the BRAM while reset is held.
    always_comb begin
        sel_cpu = 1'b0;
        sel_aux = 1'b0;
        if (reset_n_i) begin
            if (state_q == FORCE) begin
                sel_aux = aux_req_i;
            end else begin
                sel_cpu = cpu_active;
                sel_aux = ~cpu_active & aux_req_i;
            end
        end
    end

    assign addr_sel           = sel_aux ? aux_addr_i : cpu_addr_i;
    assign dmem_addr_o        = addr_sel & ~32'h3;
    assign dmem_write_data_o  = sel_aux ? aux_write_data_i : cpu_write_data_i;
    assign dmem_read_enable_o = (sel_cpu & cpu_read_enable_i) | (sel_aux & ~aux_we_i);
    assign dmem_write_mask_o  = sel_cpu ? cpu_write_mask_i :
                                (sel_aux & aux_we_i) ? aux_write_mask_i : 4'b0000;

    assign aux_gnt_o   = sel_aux;
    assign cpu_stall_o = (state_q == FORCE);

    always_comb begin
        owner_d = OWN_NONE;
        if (sel_cpu & cpu_read_enable_i) begin
            owner_d = OWN_CPU;
        end else if (sel_aux & ~aux_we_i) begin
            owner_d = OWN_AUX;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= NORMAL;
            starve_cnt_q <= 8'd0;
            owner_q      <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
            case (state_q)
                NORMAL: begin
                    if (sel_aux || !aux_req_i) begin
                        starve_cnt_q <= 8'd0;
                    end else if (cpu_active) begin
                        starve_cnt_q <= starve_cnt_inc;
                        if (starve_cnt_inc == LIMIT) begin
                            state_q <= FORCE;
                        end
                    end
                end
                FORCE: begin
                    state_q      <= NORMAL;
                    starve_cnt_q <= 8'd0;
                end
                default: begin
                    state_q      <= NORMAL;
                    starve_cnt_q <= 8'd0;
                end
            endcase
        end
    end

    assign aux_rvalid_o    = (owner_q == OWN_AUX);
    assign aux_read_data_o = dmem_read_data_i;
    assign cpu_read_data_o = dmem_read_data_i;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the CPU memory-access stage and one auxiliary requester (debug/DMA). The CPU has fixed priority with no added latency. A starvation counter guarantees the auxiliary port forward progress by stalling the CPU for one cycle. The block sits between the memory-access stage's dmem outputs and the data BRAM, and routes the BRAM's 1-cycle-latency read data back to the port that issued the read.

## Interface
- STARVE_LIMIT, 8: consecutive denied auxiliary cycles before a forced grant; legal range 1..255.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- cpu_addr_i  in  32  CPU byte address; bits [1:0] ignored.
- cpu_read_enable_i  in  1  CPU load request.
- cpu_write_data_i  in  32  CPU store data, already lane-shifted.
- cpu_write_mask_i  in  4  CPU byte write enables.
- cpu_stall_o  out  1  CPU must hold its memory-access request this cycle.
- cpu_read_data_o  out  32  load data for the CPU.
- aux_req_i  in  1  auxiliary request valid.
- aux_addr_i  in  32  auxiliary byte address; bits [1:0] ignored.
- aux_we_i  in  1  auxiliary access is a write.
- aux_write_data_i  in  32  auxiliary write data.
- aux_write_mask_i  in  4  auxiliary byte enables; used only when aux_we_i=1.
- aux_gnt_o  out  1  auxiliary request accepted this cycle.
- aux_rvalid_o  out  1  auxiliary read data valid.
- aux_read_data_o  out  32  auxiliary read data.
- dmem_addr_o  out  32  memory word address, {addr[31:2], 2'b00}.
- dmem_read_enable_o  out  1  memory read enable.
- dmem_write_data_o  out  32  memory write data.
- dmem_write_mask_o  out  4  memory byte write enables.
- dmem_read_data_i  in  32  memory read data, one cycle after the read.

## Operation
- CPU active: cpu_read_enable_i=1 or cpu_write_mask_i != 0. An auxiliary read is aux_req_i & ~aux_we_i.
- Auxiliary handshake: once aux_req_i is raised, aux_req_i and all aux_* fields stay stable until the cycle aux_gnt_o=1. The transfer completes in that cycle.
- FSM states:
  - NORMAL (reset state): CPU active selects the CPU. Otherwise aux_req_i selects the auxiliary port and asserts aux_gnt_o.
  - FORCE: cpu_stall_o=1 and the auxiliary port is selected with aux_gnt_o=aux_req_i. The CPU request is not issued.
- Starvation counter, 8 bits:
  - Cleared on any aux grant, and on any cycle with aux_req_i=0.
  - Increments on each NORMAL cycle with aux_req_i=1 and CPU active.
  - When the count reaches STARVE_LIMIT, the next state is FORCE.
  - FORCE always returns to NORMAL next cycle and clears the counter.
- Unselected requester: its signals are not driven to memory. When neither requester is selected, dmem_read_enable_o=0 and dmem_write_mask_o=0. dmem_addr_o and dmem_write_data_o then carry the CPU values.
- Read owner register (NONE/CPU/AUX): loaded each cycle with the owner of the read issued that cycle, or NONE if there was no read.
- aux_rvalid_o = (owner==AUX).
- aux_read_data_o = dmem_read_data_i; meaningful only while aux_rvalid_o=1.
- cpu_read_data_o = dmem_read_data_i, unconditional pass-through.
- Simultaneous CPU write and aux write to the same word: only the selected requester writes. No merging.

## Timing
- Grant and memory signals are combinational from the inputs and state, in the same cycle.
- Read data returns at cycle N+1 for a read issued at cycle N. aux_rvalid_o is high only in cycle N+1.
- Worst-case auxiliary wait is STARVE_LIMIT+1 cycles from aux_req_i rise to grant.
- CPU stall is at most 1 cycle per STARVE_LIMIT+1 cycles.
- Reset values:
  - state=NORMAL, counter=0, owner=NONE.
  - cpu_stall_o=0, aux_rvalid_o=0.
- While reset_n_i=0: aux_gnt_o=0, dmem_read_enable_o=0, dmem_write_mask_o=0.
- Reset mid-operation: a read issued the cycle before reset produces no aux_rvalid_o. A pending FORCE is abandoned.

## Test plan
- CPU-only traffic:
  - Load at 0x0000_1006 -> dmem_addr_o=0x0000_1004, dmem_read_enable_o=1, no stall.
  - Store mask 4'b1100 -> dmem_write_mask_o=4'b1100.
- Idle CPU, aux read at 0x40 -> aux_gnt_o=1 in the same cycle. Next cycle aux_rvalid_o=1 and aux_read_data_o equals the BRAM word at 0x40.
- Back-to-back CPU loads with aux_req_i held, STARVE_LIMIT=8 -> aux denied 8 cycles. In cycle 9, cpu_stall_o=1, aux_gnt_o=1, and the CPU request is not issued. In cycle 10, the CPU is served and the counter is 0.
- Aux write 0xDEADBEEF, mask 4'b0011 at 0x80, CPU idle -> the memory low halfword becomes 0xBEEF, the high halfword is unchanged, and aux_rvalid_o stays 0.
- CPU load issued, then aux read granted the next cycle -> cycle N+1 has owner CPU (aux_rvalid_o=0) and cycle N+2 has aux_rvalid_o=1. The two data words are distinct and correct.
- Assert reset_n_i low during a FORCE cycle with an aux read in flight -> cpu_stall_o, aux_rvalid_o and aux_gnt_o are 0 immediately. After release, state is NORMAL and the counter restarts from 0.
